// File: rtl/onehot_scan_decoder.sv
// Registered N-output one-hot decoder with a direct-select mode and a prescaled free-running scan
// mode, for multiplexed display anodes or row strobes. Optional active-low output polarity.
module onehot_scan_decoder #(
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned N_OUT      = 16,
  parameter int unsigned ACTIVE_LOW = 0,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned DIV_W      = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [SEL_W-1:0] scan_last,
  output logic [N_OUT-1:0] y,
  output logic [SEL_W-1:0] idx,
  output logic             wrap,
  output logic             err
);

  localparam logic [SEL_W:0]   NOut      = (SEL_W + 1)'(N_OUT);
  localparam logic [SEL_W-1:0] LastIdx   = SEL_W'(N_OUT - 1);
  localparam logic [DIV_W-1:0] PrescLast = DIV_W'(SCAN_DIV - 1);
  localparam logic             Inactive  = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {StIdle, StDirect, StScan} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [SEL_W-1:0] idx_d, lim;
  logic [N_OUT-1:0] y_d;
  logic             wrap_d, err_d, y_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StIdle;
    if (en) begin
      state_d = mode ? StScan : StDirect;
    end
  end

  // Next values for the output registers are decoded from the state being entered, so a mode
  // change shows up on y one cycle later with no intermediate cycle.
  always_comb begin
    lim     = (scan_last > LastIdx) ? LastIdx : scan_last;
    idx_d   = idx;
    presc_d = '0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    y_on    = 1'b0;
    unique case (state_d)
      StIdle: ;
      StDirect: begin
        idx_d = sel;
        if ({1'b0, sel} >= NOut) begin
          err_d = 1'b1;
        end else begin
          y_on = 1'b1;
        end
      end
      StScan: begin
        y_on = 1'b1;
        if (state_q != StScan) begin
          idx_d = '0;
        end else if (presc_q == PrescLast) begin
          // >= rather than == so a limit lowered below the current index still wraps.
          if (idx >= lim) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx + SEL_W'(1);
          end
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end
      default: ;
    endcase
    for (int i = 0; i < int'(N_OUT); i++) begin
      y_d[i] = Inactive ^ (y_on && (SEL_W'(i) == idx_d));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= {N_OUT{Inactive}};
      idx     <= '0;
      wrap    <= 1'b0;
      err     <= 1'b0;
      presc_q <= '0;
    end else begin
      y       <= y_d;
      idx     <= idx_d;
      wrap    <= wrap_d;
      err     <= err_d;
      presc_q <= presc_d;
    end
  end

endmodule
